melody_player: RTL and testbench
================================

Name: melody_player

Overview:
- Parametrised successor to the fixed-ROM alarm tone generator in Proyecto3.
- Plays a melody from an internal note RAM. The RAM is loaded through a write port by the RTC controller FSM.
- Adds start/stop control, per-note duration codes, a rest/articulation gap, programmable sequence length, loop mode, and busy/done status.
- Drives the board speaker with a square wave. Note frequency comes from a 12-entry semitone divider table and an octave prescaler.

Parameters:
- DEPTH, 64: number of note RAM entries. AW = clog2(DEPTH) is derived.
- TICK_DIV, 4194304: clock cycles per duration unit.
- GAP_CYCLES, 262144: silent cycles at the start of every note. Must be less than TICK_DIV.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- wr_en  in  1  note RAM write strobe
- wr_addr  in  AW  note RAM write address
- wr_data  in  8  entry: [7:6] duration code d, [5:0] fullnote (0 = rest)
- start  in  1  single-cycle start request
- stop  in  1  single-cycle abort request
- loop  in  1  replay from entry 0 after the last entry; sampled at end of sequence
- length  in  AW+1  number of entries to play; latched on an accepted start
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse on normal (non-looping) completion
- note_idx  out  AW  address of the entry currently playing
- speaker  out  1  square-wave output

Behaviour:
- Reset values (while rst_n=0 at a clk edge): state IDLE; busy=0, done=0, note_idx=0, speaker=0; all counters 0. RAM contents are not reset.
- RAM: synchronous write on wr_en. Synchronous read with 1-cycle latency. Writes are legal at any time, including during playback; they affect only entries fetched afterwards.
- State IDLE:
  - start=1, stop=0, length!=0: latch length, addr=0, go to FETCH.
  - start with length=0: done pulses next cycle; stay IDLE.
  - stop has priority over a simultaneous start.
- State FETCH (1 cycle): latch entry. Load dur_cnt = (d+1)*TICK_DIV-1. Clear the gap counter, note counter and octave counter. Go to PLAY.
- State PLAY: dur_cnt decrements every cycle. At dur_cnt=0:
  - If addr != len_latched-1: addr+1, go to FETCH.
  - Else if loop=1: addr=0, go to FETCH.
  - Else: go to IDLE and pulse done for 1 cycle.
- stop in FETCH or PLAY: go to IDLE next cycle; speaker=0; no done. start while busy is ignored.
- Timing: start at edge t gives busy=1 after edge t+1. Each entry occupies exactly 1 + (d+1)*TICK_DIV cycles (FETCH + PLAY).
- Pitch:
  - octave = fullnote/12 and semi = fullnote%12, both combinational.
  - Divider table (9 bits), semi 0..11: 511, 482, 455, 430, 405, 383, 361, 341, 322, 303, 286, 270.
  - note_cnt reloads the divider at 0, otherwise decrements.
  - When note_cnt=0, oct_cnt reloads (255>>octave) at 0, otherwise decrements.
  - speaker toggles when note_cnt=0 and oct_cnt=0.
  - Half-period = (div+1)*((255>>octave)+1) cycles.
- Silence: speaker is forced 0 and toggles are suppressed in IDLE, in FETCH, during the first GAP_CYCLES of PLAY, and for the whole of any rest entry (fullnote=0). Counters keep running during the gap.
- Octave: fullnote >= 60 gives octave 5 (max shift). Fullnote values 60..63 are legal and play semitones 0..3 of octave 5.

Test Plan (TICK_DIV=65536, GAP_CYCLES=4096, DEPTH=8):
- Load entry0=8'h3C (d=0, fullnote 60), length=1, loop=0, pulse start.
  - busy rises 1 cycle later; speaker stays 0 for 4096 PLAY cycles.
  - speaker then toggles every 4096 cycles.
  - done pulses exactly 65537 cycles after FETCH entry; busy=0.
- Entry0=8'h16 (d=0, fullnote 22 = octave 1, G) -> half-period 287*128 = 36736 cycles after the gap.
- Entries {8'h3C, 8'h00, 8'hBC}, length=3 -> note_idx runs 0,1,2.
  - Entry 1 is fully silent.
  - Entry 2 lasts 3*65536 PLAY cycles.
  - One done pulse at the end.
- loop=1, length=2 -> note_idx wraps 1->0 with no done. Drop loop during the last entry -> done at its end.
- Assert stop mid-PLAY -> IDLE next cycle, speaker=0, no done. start with length=0 -> done pulse, busy stays 0.
- Assert rst_n=0 mid-PLAY -> all outputs 0 at the next edge. start while busy -> ignored, note_idx unchanged.

Source files
------------

// File: rtl/melody_player.sv
// Note-RAM melody sequencer driving a square-wave speaker.
// Each entry holds a duration code and a semitone-indexed pitch.
module melody_player #(
    parameter int DEPTH      = 64,
    parameter int TICK_DIV   = 4194304,
    parameter int GAP_CYCLES = 262144,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
    input  logic [AW:0]   length,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] note_idx,
    output logic          speaker
);

    localparam int DW = $clog2(4 * TICK_DIV);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    rd_q;
    logic [5:0]    fullnote;
    logic [AW-1:0] addr, addr_nxt;
    logic [AW:0]   len_q;
    logic [DW-1:0] dur_cnt, dur_load;
    logic [GW-1:0] gap_cnt;
    logic [8:0]    note_cnt, div;
    logic [7:0]    oct_cnt, oct_top;
    logic [2:0]    octave;
    logic [3:0]    semi;
    logic          spk_q, done_q, done_nxt;
    logic          last, gap_open, audible, tick_n, tick_o;

    // Read address follows the next-state address so the entry is ready in FETCH.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_q <= mem[addr_nxt];
    end

    assign octave   = 3'(fullnote / 6'd12);
    assign semi     = 4'(fullnote % 6'd12);
    assign oct_top  = 8'hFF >> octave;
    assign dur_load = DW'((int'(rd_q[7:6]) + 1) * TICK_DIV - 1);

    always_comb begin
        div = 9'd511;
        unique case (semi)
            4'd0:    div = 9'd511;
            4'd1:    div = 9'd482;
            4'd2:    div = 9'd455;
            4'd3:    div = 9'd430;
            4'd4:    div = 9'd405;
            4'd5:    div = 9'd383;
            4'd6:    div = 9'd361;
            4'd7:    div = 9'd341;
            4'd8:    div = 9'd322;
            4'd9:    div = 9'd303;
            4'd10:   div = 9'd286;
            4'd11:   div = 9'd270;
            default: div = 9'd511;
        endcase
    end

    assign last     = ({1'b0, addr} == len_q - (AW+1)'(1));
    assign gap_open = (gap_cnt == GW'(GAP_CYCLES));
    assign audible  = (state == PLAY) && gap_open && (fullnote != 6'd0);
    assign tick_n   = (note_cnt == 9'd0);
    assign tick_o   = tick_n && (oct_cnt == 8'd0);

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    if (length != '0) begin
                        state_nxt = FETCH;
                        addr_nxt  = '0;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            FETCH: state_nxt = stop ? IDLE : PLAY;
            PLAY: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (dur_cnt == '0) begin
                    if (!last) begin
                        addr_nxt  = addr + AW'(1);
                        state_nxt = FETCH;
                    end else if (loop) begin
                        addr_nxt  = '0;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr     <= '0;
            len_q    <= '0;
            fullnote <= '0;
            dur_cnt  <= '0;
            gap_cnt  <= '0;
            note_cnt <= '0;
            oct_cnt  <= '0;
            spk_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            addr   <= addr_nxt;
            done_q <= done_nxt;
            if (state == IDLE && state_nxt == FETCH) len_q <= length;
            if (state == FETCH) begin
                fullnote <= rd_q[5:0];
                dur_cnt  <= dur_load;
                gap_cnt  <= '0;
                note_cnt <= '0;
                oct_cnt  <= '0;
            end else if (state == PLAY) begin
                if (dur_cnt != '0) dur_cnt <= dur_cnt - DW'(1);
                if (!gap_open) gap_cnt <= gap_cnt + GW'(1);
                note_cnt <= tick_n ? div : note_cnt - 9'd1;
                if (tick_n) oct_cnt <= (oct_cnt == 8'd0) ? oct_top : oct_cnt - 8'd1;
            end
            // Phase restarts from low whenever the output is muted.
            spk_q <= audible ? (spk_q ^ tick_o) : 1'b0;
        end
    end

    assign busy     = (state != IDLE);
    assign done     = done_q;
    assign note_idx = addr;
    assign speaker  = spk_q & audible;

endmodule

// File: tb/tb_melody_player.sv
// Randomized and directed bench for melody_player against a
// cycle-offset reference model of the note sequencer.
module tb_melody_player;

    localparam int DEPTH = 8;
    localparam int TICK  = 2048;
    localparam int GAP   = 128;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop = 1'b0;
    logic [AW:0]   length = '0;
    logic          busy, done, speaker;
    logic [AW-1:0] note_idx;

    int total = 0;
    int bad = 0;

    bit         m_busy = 0;
    bit         m_done = 0;
    int         m_idx = 0;
    int         m_len = 0;
    int         m_k = 0;
    logic [7:0] m_ent = '0;
    logic [7:0] m_mem [DEPTH];

    always #5 clk = ~clk;

    melody_player #(
        .DEPTH(DEPTH),
        .TICK_DIV(TICK),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .start(start),
        .stop(stop),
        .loop(loop),
        .length(length),
        .busy(busy),
        .done(done),
        .note_idx(note_idx),
        .speaker(speaker)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    function automatic int half_period(input logic [5:0] fn);
        int tbl [12] = '{511, 482, 455, 430, 405, 383,
                         361, 341, 322, 303, 286, 270};
        int oct = int'(fn) / 12;
        int sm  = int'(fn) % 12;
        return (tbl[sm] + 1) * ((255 >> oct) + 1);
    endfunction

    // m_k counts cycles since FETCH; PLAY cycle p = m_k-1.
    function automatic int exp_speaker();
        int p, h, cnt;
        if (!m_busy || m_k == 0) return 0;
        p = m_k - 1;
        if (m_ent[5:0] == 6'd0 || p < GAP) return 0;
        h = half_period(m_ent[5:0]);
        cnt = (p - 1) / h - (GAP - 1) / h;
        return cnt % 2;
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_busy = 0;
            m_done = 0;
            m_idx = 0;
            m_k = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (start && !stop) begin
                    if (length != '0) begin
                        m_busy = 1;
                        m_idx = 0;
                        m_len = int'(length);
                        m_k = 0;
                        m_ent = m_mem[0];
                    end else begin
                        m_done = 1;
                    end
                end
            end else if (stop) begin
                m_busy = 0;
            end else if (m_k == (int'(m_ent[7:6]) + 1) * TICK) begin
                if (m_idx != m_len - 1) begin
                    m_idx++;
                    m_k = 0;
                    m_ent = m_mem[m_idx];
                end else if (loop) begin
                    m_idx = 0;
                    m_k = 0;
                    m_ent = m_mem[0];
                end else begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else begin
                m_k++;
            end
        end
        if (wr_en) m_mem[wr_addr] = wr_data;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("busy", int'(busy), int'(m_busy));
        chk("done", int'(done), int'(m_done));
        chk("speaker", int'(speaker), exp_speaker());
        if (m_busy) chk("note_idx", int'(note_idx), m_idx);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = 8'(d);
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(input int len, input bit lp);
        length = (AW+1)'(len);
        loop = lp;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    initial begin
        repeat (3) step();
        wait_neg(1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_speaker", int'(speaker), 0);
        chk("rst_idx", int'(note_idx), 0);
        step();
        rst_n = 1'b1;
        for (int a = 0; a < DEPTH; a++) wr(a, 0);

        // Single note 60, d=2: toggles every 4096 cycles after the gap.
        wr(0, 8'hBC);
        pulse_start(1, 0);
        wait_neg(1);
        chk("t1_busy_rise", int'(busy), 1);
        wait_neg(4097);
        chk("t1_spk_low", int'(speaker), 0);
        wait_neg(1);
        chk("t1_spk_high", int'(speaker), 1);
        wait_neg(2046);
        chk("t1_pre_done", int'(done), 0);
        wait_neg(1);
        chk("t1_done", int'(done), 1);
        chk("t1_idle", int'(busy), 0);
        wait_neg(1);
        chk("t1_done_pulse", int'(done), 0);

        // Three entries with a rest in the middle.
        wr(0, 8'h3C);
        wr(1, 8'h00);
        wr(2, 8'hBC);
        pulse_start(3, 0);
        wait_neg(2050);
        chk("t2_idx1", int'(note_idx), 1);
        wait_neg(2049);
        chk("t2_idx2", int'(note_idx), 2);
        wait_neg(6145);
        chk("t2_done", int'(done), 1);

        // Loop wraps once, then loop is dropped during the last entry.
        wr(0, 8'h3C);
        wr(1, 8'h3D);
        pulse_start(2, 1);
        wait_neg(4099);
        chk("t3_wrap_idx", int'(note_idx), 0);
        chk("t3_wrap_busy", int'(busy), 1);
        wait_neg(2049);
        chk("t3_idx1", int'(note_idx), 1);
        loop = 1'b0;
        wait_neg(2049);
        chk("t3_done", int'(done), 1);

        // Stop mid-note.
        wr(0, 8'hFC);
        pulse_start(1, 0);
        wait_neg(4500);
        chk("t4_spk_on", int'(speaker), 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_neg(1);
        chk("t4_stop_busy", int'(busy), 0);
        chk("t4_stop_spk", int'(speaker), 0);
        chk("t4_stop_done", int'(done), 0);

        // Start while busy is ignored.
        wr(0, 8'h7C);
        pulse_start(1, 0);
        wait_neg(100);
        pulse_start(2, 0);
        wait_neg(1);
        chk("t4_ign_idx", int'(note_idx), 0);
        wait_idle(6000);

        // Zero length and stop-over-start in IDLE.
        pulse_start(0, 0);
        wait_neg(1);
        chk("t4_len0_done", int'(done), 1);
        chk("t4_len0_busy", int'(busy), 0);
        stop = 1'b1;
        pulse_start(1, 0);
        stop = 1'b0;
        wait_neg(1);
        chk("t4_prio_busy", int'(busy), 0);

        // Reset mid-note.
        wr(0, 8'hFC);
        pulse_start(1, 0);
        wait_neg(4400);
        chk("t5_spk_on", int'(speaker), 1);
        rst_n = 1'b0;
        step();
        wait_neg(1);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_spk", int'(speaker), 0);
        chk("t5_rst_idx", int'(note_idx), 0);
        chk("t5_rst_done", int'(done), 0);
        step();
        rst_n = 1'b1;

        // Random melodies, one aborted at a random point.
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                int d, fn;
                d = int'($urandom_range(0, 1));
                fn = int'($urandom_range(36, 63));
                if ($urandom_range(0, 5) == 0) fn = 0;
                wr(a, d * 64 + fn);
            end
            pulse_start(int'($urandom_range(1, 3)), 0);
            if (r == 2) begin
                wait_neg(int'($urandom_range(10, 3000)));
                stop = 1'b1;
                step();
                stop = 1'b0;
            end
            wait_idle(14000);
            step();
        end

        wait_neg(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
